// File: rtl/register_mode_n.sv
// register_mode_n: WIDTH-bit signed register with synchronous active-low
// reset, parallel load and an op-selected in-place update (inc/dec/shift/
// rotate/clear). Carry and overflow are registered with out; zero and
// negative are decoded combinationally from the register contents.
module register_mode_n #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SATURATE  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] in,
    input  logic                    load,
    input  logic [2:0]              op,
    output logic signed [WIDTH-1:0] out,
    output logic                    cy,
    output logic                    ov,
    output logic                    zr,
    output logic                    ng
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_INC  = 3'b001,
        OP_DEC  = 3'b010,
        OP_SHL  = 3'b011,
        OP_SHR  = 3'b100,
        OP_SAR  = 3'b101,
        OP_ROL  = 3'b110,
        OP_CLR  = 3'b111
    } op_e;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] out_q;
    logic             cy_q;
    logic             ov_q;

    logic [WIDTH-1:0] nxt_out;
    logic             nxt_cy;
    logic             nxt_ov;

    logic [WIDTH:0]   inc_sum;
    logic [WIDTH-1:0] dec_diff;
    op_e              op_dec;

    assign op_dec   = op_e'(op);
    assign inc_sum  = {1'b0, out_q} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_diff = out_q - {{(WIDTH-1){1'b0}}, 1'b1};

    // Next-value decode for the in-place update ops (load/reset handled in the register).
    always_comb begin
        nxt_out = out_q;
        nxt_cy  = cy_q;
        nxt_ov  = ov_q;
        case (op_dec)
            OP_HOLD: ;
            OP_INC: begin
                if (SATURATE && out_q == MAX_POS) begin
                    nxt_cy = 1'b0;
                    nxt_ov = 1'b1;
                end else begin
                    nxt_out = inc_sum[WIDTH-1:0];
                    nxt_cy  = inc_sum[WIDTH];
                    nxt_ov  = (out_q == MAX_POS);
                end
            end
            OP_DEC: begin
                if (SATURATE && out_q == MIN_NEG) begin
                    nxt_cy = 1'b0;
                    nxt_ov = 1'b1;
                end else begin
                    nxt_out = dec_diff;
                    nxt_cy  = (out_q == '0);
                    nxt_ov  = (out_q == MIN_NEG);
                end
            end
            OP_SHL: begin
                nxt_out = {out_q[WIDTH-2:0], 1'b0};
                nxt_cy  = out_q[WIDTH-1];
                nxt_ov  = out_q[WIDTH-1] ^ out_q[WIDTH-2];
            end
            OP_SHR: begin
                nxt_out = {1'b0, out_q[WIDTH-1:1]};
                nxt_cy  = out_q[0];
                nxt_ov  = 1'b0;
            end
            OP_SAR: begin
                nxt_out = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
                nxt_cy  = out_q[0];
                nxt_ov  = 1'b0;
            end
            OP_ROL: begin
                nxt_out = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                nxt_cy  = out_q[WIDTH-1];
                nxt_ov  = 1'b0;
            end
            OP_CLR: begin
                nxt_out = '0;
                nxt_cy  = 1'b0;
                nxt_ov  = 1'b0;
            end
        endcase
    end

    // State register: reset beats load, load beats the op update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= RESET_VAL;
            cy_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else if (load) begin
            out_q <= in;
            cy_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            out_q <= nxt_out;
            cy_q  <= nxt_cy;
            ov_q  <= nxt_ov;
        end
    end

    assign out = out_q;
    assign cy  = cy_q;
    assign ov  = ov_q;
    assign zr  = (out_q == '0);
    assign ng  = out_q[WIDTH-1];

endmodule

// File: tb/tb_register_mode_n.sv
// Bench for register_mode_n: three instances (16-bit wrap, 16-bit saturate,
// 4-bit wrap with RESET_VAL=5) share one stimulus stream and are compared
// every cycle against an integer-arithmetic model, plus literal spot checks.
module tb_register_mode_n;

    localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, DEC = 3'd2, SHL = 3'd3,
                           SHR = 3'd4, SAR = 3'd5, ROL = 3'd6, CLR = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] din = '0;

    logic signed [15:0] o16, o16s;
    logic signed [3:0]  o4;
    logic               cy16, ov16, zr16, ng16;
    logic               cy16s, ov16s, zr16s, ng16s;
    logic               cy4, ov4, zr4, ng4;
    logic signed [3:0]  din4;

    assign din4 = din[3:0];

    int n_checks = 0;
    int n_fail   = 0;

    register_mode_n #(.WIDTH(16), .RESET_VAL(16'h0000), .SATURATE(1'b0)) d16 (
        .clk(clk), .rst_n(rst_n), .in(din), .load(load), .op(op),
        .out(o16), .cy(cy16), .ov(ov16), .zr(zr16), .ng(ng16));

    register_mode_n #(.WIDTH(16), .RESET_VAL(16'h0000), .SATURATE(1'b1)) d16s (
        .clk(clk), .rst_n(rst_n), .in(din), .load(load), .op(op),
        .out(o16s), .cy(cy16s), .ov(ov16s), .zr(zr16s), .ng(ng16s));

    register_mode_n #(.WIDTH(4), .RESET_VAL(4'h5), .SATURATE(1'b0)) d4 (
        .clk(clk), .rst_n(rst_n), .in(din4), .load(load), .op(op),
        .out(o4), .cy(cy4), .ov(ov4), .zr(zr4), .ng(ng4));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mw[3]   = '{16, 16, 4};
    bit msat[3] = '{1'b0, 1'b1, 1'b0};
    int mrv[3]  = '{0, 0, 5};
    int mv[3];
    bit mc[3];
    bit mf[3];
    bit valid = 1'b0;

    // One register update expressed as modular integer arithmetic.
    function automatic void step(input int w, input bit sat, input bit r_n,
                                 input bit ld, input int d, input logic [2:0] o,
                                 input int rv, inout int v, inout bit c, inout bit f);
        int md, half, s;
        md   = 1 << w;
        half = md / 2;
        s    = (v >= half) ? v - md : v;
        if (!r_n) begin
            v = rv; c = 0; f = 0;
        end else if (ld) begin
            v = d % md; c = 0; f = 0;
        end else begin
            case (o)
                HOLD: ;
                INC: if (sat && s == half - 1) begin c = 0; f = 1; end
                     else begin c = (v + 1 == md); f = (s == half - 1); v = (v + 1) % md; end
                DEC: if (sat && s == -half) begin c = 0; f = 1; end
                     else begin c = (v == 0); f = (s == -half); v = (v + md - 1) % md; end
                SHL: begin
                    c = (v >= half);
                    f = ((v >= half) != (((v * 2) % md) >= half));
                    v = (v * 2) % md;
                end
                SHR: begin c = v % 2; f = 0; v = v / 2; end
                SAR: begin c = v % 2; f = 0; v = v / 2 + ((v >= half) ? half : 0); end
                ROL: begin c = (v >= half); f = 0; v = (v * 2) % md + int'(c); end
                default: begin v = 0; c = 0; f = 0; end
            endcase
        end
    endfunction

    // Model advances on the same edge as the DUTs, using the inputs held since the last edge.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            step(mw[i], msat[i], rst_n, load, int'(din), op, mrv[i], mv[i], mc[i], mf[i]);
        if (!rst_n) valid = 1'b1;
    end

    // Compare every instance against the model mid-cycle once state is defined.
    always @(negedge clk) begin
        if (valid) begin
            chk("d16.out", int'(unsigned'(o16)), mv[0]);
            chk("d16.cy", int'(cy16), int'(mc[0]));
            chk("d16.ov", int'(ov16), int'(mf[0]));
            chk("d16.zr", int'(zr16), int'(mv[0] == 0));
            chk("d16.ng", int'(ng16), int'(mv[0] >= 32768));
            chk("d16s.out", int'(unsigned'(o16s)), mv[1]);
            chk("d16s.cy", int'(cy16s), int'(mc[1]));
            chk("d16s.ov", int'(ov16s), int'(mf[1]));
            chk("d16s.zr", int'(zr16s), int'(mv[1] == 0));
            chk("d16s.ng", int'(ng16s), int'(mv[1] >= 32768));
            chk("d4.out", int'(unsigned'(o4)), mv[2]);
            chk("d4.cy", int'(cy4), int'(mc[2]));
            chk("d4.ov", int'(ov4), int'(mf[2]));
            chk("d4.zr", int'(zr4), int'(mv[2] == 0));
            chk("d4.ng", int'(ng4), int'(mv[2] >= 8));
        end
    end

    // Apply one cycle of stimulus, then return just after the edge that consumed it.
    task automatic cyc(input bit r_n, input bit ld, input logic [15:0] d, input logic [2:0] o);
        rst_n = r_n; load = ld; din = d; op = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // reset wins over load
        cyc(0, 1, 16'h1234, HOLD);
        chk("rst.out", int'(unsigned'(o16)), 0);
        chk("rst.cy", int'(cy16), 0);
        chk("rst.ov", int'(ov16), 0);
        chk("rst.zr", int'(zr16), 1);
        chk("rst.d4", int'(unsigned'(o4)), 5);
        cyc(1, 1, 16'h1234, HOLD);
        chk("load.out", int'(unsigned'(o16)), 16'h1234);
        // wrap
        cyc(1, 1, 16'hFFFF, HOLD);
        cyc(1, 0, 16'h0, INC);
        chk("wrap.inc.out", int'(unsigned'(o16)), 0);
        chk("wrap.inc.cy", int'(cy16), 1);
        chk("wrap.inc.zr", int'(zr16), 1);
        chk("wrap.inc.ov", int'(ov16), 0);
        cyc(1, 0, 16'h0, DEC);
        chk("wrap.dec.out", int'(unsigned'(o16)), 16'hFFFF);
        chk("wrap.dec.cy", int'(cy16), 1);
        chk("wrap.dec.ng", int'(ng16), 1);
        // overflow / saturate
        cyc(1, 1, 16'h7FFF, HOLD);
        cyc(1, 0, 16'h0, INC);
        chk("ovf.inc.out", int'(unsigned'(o16)), 16'h8000);
        chk("ovf.inc.ov", int'(ov16), 1);
        chk("sat.inc.out", int'(unsigned'(o16s)), 16'h7FFF);
        chk("sat.inc.ov", int'(ov16s), 1);
        chk("sat.inc.cy", int'(cy16s), 0);
        cyc(1, 1, 16'h8000, HOLD);
        cyc(1, 0, 16'h0, DEC);
        chk("sat.dec.out", int'(unsigned'(o16s)), 16'h8000);
        chk("sat.dec.ov", int'(ov16s), 1);
        chk("ovf.dec.out", int'(unsigned'(o16)), 16'h7FFF);
        // shifts
        cyc(1, 1, 16'h8001, HOLD); cyc(1, 0, 16'h0, SHL);
        chk("shl.out", int'(unsigned'(o16)), 16'h0002);
        chk("shl.cy", int'(cy16), 1);
        chk("shl.ov", int'(ov16), 1);
        cyc(1, 1, 16'h8001, HOLD); cyc(1, 0, 16'h0, SHR);
        chk("shr.out", int'(unsigned'(o16)), 16'h4000);
        chk("shr.cy", int'(cy16), 1);
        cyc(1, 1, 16'h8001, HOLD); cyc(1, 0, 16'h0, SAR);
        chk("sar.out", int'(unsigned'(o16)), 16'hC000);
        chk("sar.cy", int'(cy16), 1);
        cyc(1, 1, 16'h8001, HOLD); cyc(1, 0, 16'h0, ROL);
        chk("rol.out", int'(unsigned'(o16)), 16'h0003);
        chk("rol.cy", int'(cy16), 1);
        // priority and hold
        cyc(1, 1, 16'h00AA, CLR);
        chk("prio.out", int'(unsigned'(o16)), 16'h00AA);
        chk("prio.cy", int'(cy16), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 16'h0, HOLD);
            chk("hold.out", int'(unsigned'(o16)), 16'h00AA);
        end
        cyc(0, 0, 16'h0, INC);
        chk("rst.mid.out", int'(unsigned'(o16)), 0);
        // narrow instance
        cyc(0, 0, 16'h0, HOLD);
        chk("w4.rst", int'(unsigned'(o4)), 5);
        cyc(1, 0, 16'h0, INC);
        cyc(1, 0, 16'h0, INC);
        chk("w4.inc7", int'(unsigned'(o4)), 7);
        cyc(1, 0, 16'h0, INC);
        chk("w4.inc8", int'(unsigned'(o4)), 8);
        chk("w4.ov", int'(ov4), 1);
        cyc(1, 0, 16'h0, ROL);
        chk("w4.rol.out", int'(unsigned'(o4)), 1);
        chk("w4.rol.cy", int'(cy4), 1);
        // randomized traffic, biased toward the signed/unsigned edge values
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] d;
            int sel;
            sel = $urandom_range(0, 5);
            case (sel)
                0: d = 16'h7FFF;
                1: d = 16'h8000;
                2: d = 16'hFFFF;
                3: d = 16'h0000;
                default: d = 16'($urandom);
            endcase
            cyc($urandom_range(0, 99) >= 3, $urandom_range(0, 99) < 20, d,
                3'($urandom_range(0, 7)));
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
